// File: rtl/oam_dma.sv
// Sprite-attribute DMA: on a write to the page register, copies OAM_BYTES bytes
// from {page, 8'h00} into OAM. The copy is paced one byte per tick.
module oam_dma #(
    parameter logic [15:0] REG_ADDR  = 16'hFF46,
    parameter int          OAM_BYTES = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_rdata,
    input  logic        tick,
    output logic [15:0] src_addr,
    output logic        src_rd,
    input  logic [7:0]  src_data,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_active,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, ARM, XFER, WR} state_t;

    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

    state_t     state, state_nxt;
    logic [7:0] page;
    logic [7:0] idx, idx_nxt;
    logic [7:0] rdata_p1;
    logic       done_p1, done_nxt;
    logic       reg_hit, reg_wr;
    logic       src_rd_c, oam_we_c;

    // Pages E0..FF alias the work RAM at C0..DF.
    function automatic logic [7:0] echo_fold(input logic [7:0] p);
        return (p >= 8'hE0) ? (p - 8'h20) : p;
    endfunction

    assign reg_hit = (cpu_addr == REG_ADDR);
    assign reg_wr  = reg_hit && cpu_wr;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        src_rd_c  = 1'b0;
        oam_we_c  = 1'b0;
        if (reg_wr) begin
            // A fresh page write restarts the copy from byte 0, whatever was in flight.
            state_nxt = ARM;
            idx_nxt   = 8'h00;
        end else begin
            unique case (state)
                IDLE: state_nxt = IDLE;
                ARM:  if (tick) state_nxt = XFER;
                XFER: begin
                    if (tick) begin
                        src_rd_c  = 1'b1;
                        state_nxt = WR;
                    end
                end
                WR: begin
                    oam_we_c = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                        idx_nxt   = 8'h00;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = XFER;
                        idx_nxt   = idx + 8'h01;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            done_p1  <= 1'b0;
            rdata_p1 <= 8'h00;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            done_p1  <= done_nxt;
            rdata_p1 <= (reg_hit && cpu_rd) ? page : 8'h00;
            if (reg_wr) page <= cpu_wdata;
        end
    end

    // Strobes are combinational so src_data lines up with the WR cycle; reset masks them.
    assign src_rd     = src_rd_c && !reset;
    assign oam_we     = oam_we_c && !reset;
    assign src_addr   = src_rd ? {echo_fold(page), idx} : 16'h0000;
    assign oam_addr   = oam_we ? idx : 8'h00;
    assign oam_wdata  = oam_we ? src_data : 8'h00;
    assign dma_active = ((state == XFER) || (state == WR)) && !reset;
    assign done       = done_p1 && !reset;
    assign cpu_rdata  = rdata_p1;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: full copies, echo-page folding, restart, reset abort, readback.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_rdata;
    logic        tick;
    logic [15:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_data;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_active;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Scoreboard state updated by the monitor
    int          we_cnt, src_cnt, done_cnt;
    logic [7:0]  exp_idx;
    logic [15:0] exp_src_base, first_src, last_src;

    oam_dma #(.REG_ADDR(16'hFF46), .OAM_BYTES(160)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_rdata(cpu_rdata), .tick(tick),
        .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
        .dma_active(dma_active), .done(done)
    );

    always #5 clk = ~clk;

    // Source memory: data = low address byte ^ 5A, one cycle after the read
    always @(posedge clk) src_data <= src_addr[7:0] ^ 8'h5A;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (src_rd) begin
            check("src_addr_seq", src_addr, exp_src_base + 16'(src_cnt));
            if (src_cnt == 0) first_src = src_addr;
            last_src = src_addr;
            src_cnt++;
        end
        if (oam_we) begin
            check("oam_addr_seq", oam_addr, exp_idx);
            check("oam_wdata", oam_wdata, exp_idx ^ 8'h5A);
            exp_idx++;
            we_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic clear_mon(input logic [15:0] base);
        we_cnt = 0; src_cnt = 0; done_cnt = 0; exp_idx = 8'h00;
        exp_src_base = base; first_src = 16'hxxxx; last_src = 16'hxxxx;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
        cpu_wr = 1'b0; cpu_rd = 1'b0; tick = 1'b0;
    endtask

    task automatic reg_write(input logic [7:0] v);
        cpu_addr = 16'hFF46; cpu_wdata = v; cpu_wr = 1'b1;
        next_cycle();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            next_cycle();
            repeat (3) next_cycle();
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {20'h0, src_rd, oam_we, done, dma_active, cpu_rdata, src_addr, oam_addr, oam_wdata};
    endfunction

    initial begin
        reset = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        cpu_wr = 1'b0; cpu_rd = 1'b0; tick = 1'b0;
        clear_mon(16'h0000);
        repeat (2) next_cycle();
        check("reset_outputs", all_outs(), 64'h0);
        reset = 1'b0;
        next_cycle();

        // Readback of the page register
        reg_write(8'h12);
        cpu_addr = 16'hFF46; cpu_rd = 1'b1;
        next_cycle();
        check("rdata_hit", cpu_rdata, 8'h12);
        next_cycle();
        check("rdata_after", cpu_rdata, 8'h00);
        cpu_addr = 16'hFF47; cpu_rd = 1'b1;
        next_cycle();
        check("rdata_miss", cpu_rdata, 8'h00);

        // Full copy from page C1, with a back-to-back tick pair in the middle
        reg_write(8'hC1);
        clear_mon(16'hC100);
        check("arm_inactive", dma_active, 1'b0);
        run_ticks(1);
        check("xfer_active", dma_active, 1'b1);
        run_ticks(50);
        tick = 1'b1;
        next_cycle();
        tick = 1'b1; #1;
        check("dbl_tick_we", oam_we, 1'b1);
        check("dbl_tick_no_rd", src_rd, 1'b0);
        repeat (3) next_cycle();
        check("dbl_tick_one_rd", src_cnt, 51);
        run_ticks(108);
        check("c1_we_159", we_cnt, 159);
        check("c1_no_early_done", done_cnt, 0);
        run_ticks(1);
        check("c1_we_cnt", we_cnt, 160);
        check("c1_src_cnt", src_cnt, 160);
        check("c1_done_once", done_cnt, 1);
        check("c1_first_src", first_src, 16'hC100);
        check("c1_last_src", last_src, 16'hC19F);
        check("c1_idle", dma_active, 1'b0);

        // Echo page E3 folds to C3
        reg_write(8'hE3);
        clear_mon(16'hC300);
        run_ticks(161);
        check("e3_first_src", first_src, 16'hC300);
        check("e3_last_src", last_src, 16'hC39F);
        check("e3_we_cnt", we_cnt, 160);
        check("e3_done", done_cnt, 1);

        // Restart by a register write landing in the WR cycle of byte 37
        reg_write(8'hC1);
        clear_mon(16'hC100);
        run_ticks(38);
        tick = 1'b1;
        next_cycle();
        cpu_addr = 16'hFF46; cpu_wdata = 8'h80; cpu_wr = 1'b1; #1;
        check("restart_no_we", oam_we, 1'b0);
        next_cycle();
        check("restart_we_cnt", we_cnt, 37);
        check("restart_arm_inactive", dma_active, 1'b0);
        check("restart_no_done", done_cnt, 0);
        clear_mon(16'h8000);
        run_ticks(160);
        check("restart_done_wait", done_cnt, 0);
        run_ticks(1);
        check("restart_first_src", first_src, 16'h8000);
        check("restart_we_cnt_new", we_cnt, 160);
        check("restart_done", done_cnt, 1);

        // Reset during the WR cycle of byte 100
        reg_write(8'hC1);
        clear_mon(16'hC100);
        run_ticks(101);
        tick = 1'b1;
        next_cycle();
        reset = 1'b1; #1;
        check("reset_wr_outputs", all_outs(), 64'h0);
        next_cycle();
        reset = 1'b0; #1;
        check("post_reset_outputs", all_outs(), 64'h0);
        run_ticks(3);
        check("abort_we_cnt", we_cnt, 100);
        check("abort_no_done", done_cnt, 0);
        cpu_addr = 16'hFF46; cpu_rd = 1'b1;
        next_cycle();
        check("abort_page_cleared", cpu_rdata, 8'h00);

        // Reset beats a simultaneous register write
        reset = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = 8'h55; cpu_wr = 1'b1;
        next_cycle();
        reset = 1'b0;
        run_ticks(1);
        check("reset_prio_idle", dma_active, 1'b0);
        cpu_rd = 1'b1;
        next_cycle();
        check("reset_prio_page", cpu_rdata, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
